// File: rtl/prod_pkg.sv
// Shared definitions for the burst producer: FSM state encoding, default LFSR seed
// and the helper that maps a raw LFSR byte into an inclusive [lo, hi] range.
package prod_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_PRODUCE = 2'd1,
      ST_WAIT    = 2'd2
   } state_e;

   localparam logic [15:0] DEFAULT_SEED = 16'hACE1;

   function automatic logic [7:0] pick_in_range(input logic [7:0] raw, input int lo, input int hi);
      int v;
      v = lo + (int'(raw) % (hi - lo + 1));
      return v[7:0];
   endfunction

endpackage

// File: rtl/lfsr16.sv
// 16-bit Fibonacci LFSR, taps 16,14,13,11, shifting right one step every clock.
module lfsr16 (
   input  logic        clk,
   input  logic        rst_b,
   input  logic [15:0] seed,
   output logic [15:0] out
);

   logic w_fb;

   // Tap n of the polynomial sits at bit (16-n) of a right-shifting register.
   assign w_fb = out[0] ^ out[2] ^ out[3] ^ out[5];

   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) out <= seed;
      else        out <= {w_fb, out[15:1]};
   end

endmodule

// File: rtl/prod_gen.sv
// Burst producer: emits bursts of random length separated by random idle gaps,
// with counter or LFSR payload, honouring consumer backpressure.
module prod_gen
   import prod_pkg::*;
#(
   parameter int          DATA_W  = 8,
   parameter int          MODE    = 0,
   parameter int          LEN_MIN = 3,
   parameter int          LEN_MAX = 5,
   parameter int          GAP_MIN = 1,
   parameter int          GAP_MAX = 4,
   parameter logic [15:0] SEED    = DEFAULT_SEED
) (
   input  logic              clk,
   input  logic              rst_b,
   input  logic              en,
   input  logic              rdy,
   output logic              val,
   output logic [DATA_W-1:0] data,
   output logic              last,
   output logic [15:0]       bursts
);

   localparam logic [15:0] SEED_EFF = (SEED == 16'h0000) ? DEFAULT_SEED : SEED;

   if (DATA_W < 1 || DATA_W > 16 || (MODE != 0 && MODE != 1) ||
       LEN_MIN < 1 || LEN_MIN > LEN_MAX || LEN_MAX > 255 ||
       GAP_MIN < 0 || GAP_MIN > GAP_MAX || GAP_MAX > 255) begin : g_param_check
      $error("prod_gen: illegal parameter combination");
   end

   state_e      r_state;
   logic [7:0]  r_len;
   logic [7:0]  r_beat;
   logic [7:0]  r_gap;

   logic [15:0] w_lfsr;
   logic [7:0]  w_len_next;
   logic [7:0]  w_gap_next;
   logic        w_xfer;
   logic        w_xfer_last;
   logic        w_burst_slot;
   logic        w_start;

   lfsr16 u_lfsr (
      .clk   (clk),
      .rst_b (rst_b),
      .seed  (SEED_EFF),
      .out   (w_lfsr)
   );

   assign w_len_next  = pick_in_range(w_lfsr[7:0],  LEN_MIN, LEN_MAX);
   assign w_gap_next  = pick_in_range(w_lfsr[15:8], GAP_MIN, GAP_MAX);
   assign w_xfer      = (r_state == ST_PRODUCE) && val && rdy;
   assign w_xfer_last = w_xfer && (r_beat == r_len);

   // Edges at which a new burst may begin: idle (or any stray encoding), the final
   // gap cycle, or the last beat itself when the drawn gap is zero.
   assign w_burst_slot = ((r_state != ST_PRODUCE) && (r_state != ST_WAIT))
                       || ((r_state == ST_WAIT) && (r_gap == 8'd1))
                       || (w_xfer_last && (w_gap_next == 8'd0));
   assign w_start      = w_burst_slot && en;

   // NOTE: every output is a flop updated with <= so all of them change together
   // on the edge and no consumer ever sees a combinational glitch from rdy or en.
   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         r_state <= ST_IDLE;
         r_len   <= '0;
         r_beat  <= '0;
         r_gap   <= '0;
         val     <= 1'b0;
         last    <= 1'b0;
         data    <= '0;
         bursts  <= '0;
      end else begin
         if (w_start) begin
            r_state <= ST_PRODUCE;
            r_len   <= w_len_next;
            r_beat  <= 8'd1;
            val     <= 1'b1;
            last    <= (w_len_next == 8'd1);
         end else if (w_xfer_last && (w_gap_next != 8'd0)) begin
            r_state <= ST_WAIT;
            r_gap   <= w_gap_next;
            val     <= 1'b0;
            last    <= 1'b0;
         end else if (w_burst_slot) begin
            r_state <= ST_IDLE;
            val     <= 1'b0;
            last    <= 1'b0;
         end else if (w_xfer) begin
            r_beat  <= r_beat + 8'd1;
            last    <= ((r_beat + 8'd1) == r_len);
         end else if (r_state == ST_WAIT) begin
            r_gap   <= r_gap - 8'd1;
         end

         if (w_xfer_last) bursts <= bursts + 16'd1;

         if (MODE == 0) begin
            if (w_xfer) data <= data + DATA_W'(1);
         end else begin
            if (w_start || (w_xfer && !w_xfer_last)) data <= w_lfsr[DATA_W-1:0];
         end
      end
   end

endmodule

// File: tb/tb_prod_gen.sv
// Bench for prod_gen: directed vector table and hand-written corner sequences on
// several parameterisations, plus randomized en/rdy against a beat-countdown model.
module tb_prod_gen;

   localparam int R_LEN_MIN = 3;
   localparam int R_LEN_MAX = 5;
   localparam int R_GAP_MIN = 1;
   localparam int R_GAP_MAX = 4;

   typedef struct {
      bit en;
      bit rdy;
      bit val;
      int data;
      bit last;
      int bursts;
   } vec_t;

   typedef struct {
      bit          val;
      bit          last;
      int          data;
      int          bursts;
      int          remaining;
      int          gap;
      int unsigned lfsr;
   } model_t;

   logic clk = 1'b1;
   logic rst_b;
   logic en;
   logic rdy;

   logic        a_val, a_last;  logic [7:0] a_data;  logic [15:0] a_bursts;
   logic        b_val, b_last;  logic [7:0] b_data;  logic [15:0] b_bursts;
   logic        c_val, c_last;  logic [3:0] c_data;  logic [15:0] c_bursts;
   logic        r_val, r_last;  logic [7:0] r_data;  logic [15:0] r_bursts;
   logic        m_val, m_last;  logic [7:0] m_data;  logic [15:0] m_bursts;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   prod_gen #(.DATA_W(8), .MODE(0), .LEN_MIN(3), .LEN_MAX(3), .GAP_MIN(2), .GAP_MAX(2)) u_a (
      .clk(clk), .rst_b(rst_b), .en(en), .rdy(rdy),
      .val(a_val), .data(a_data), .last(a_last), .bursts(a_bursts));

   prod_gen #(.DATA_W(8), .MODE(0), .LEN_MIN(2), .LEN_MAX(2), .GAP_MIN(0), .GAP_MAX(0)) u_b (
      .clk(clk), .rst_b(rst_b), .en(en), .rdy(rdy),
      .val(b_val), .data(b_data), .last(b_last), .bursts(b_bursts));

   prod_gen #(.DATA_W(4), .MODE(0), .LEN_MIN(3), .LEN_MAX(3), .GAP_MIN(0), .GAP_MAX(0)) u_c (
      .clk(clk), .rst_b(rst_b), .en(en), .rdy(rdy),
      .val(c_val), .data(c_data), .last(c_last), .bursts(c_bursts));

   prod_gen #(.DATA_W(8), .MODE(0), .LEN_MIN(R_LEN_MIN), .LEN_MAX(R_LEN_MAX),
              .GAP_MIN(R_GAP_MIN), .GAP_MAX(R_GAP_MAX)) u_r (
      .clk(clk), .rst_b(rst_b), .en(en), .rdy(rdy),
      .val(r_val), .data(r_data), .last(r_last), .bursts(r_bursts));

   prod_gen #(.DATA_W(8), .MODE(1), .LEN_MIN(R_LEN_MIN), .LEN_MAX(R_LEN_MAX),
              .GAP_MIN(R_GAP_MIN), .GAP_MAX(R_GAP_MAX), .SEED(16'h0000)) u_m (
      .clk(clk), .rst_b(rst_b), .en(en), .rdy(rdy),
      .val(m_val), .data(m_data), .last(m_last), .bursts(m_bursts));

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
      end
   endtask

   // Drive inputs for the coming rising edge, then return at the following falling edge.
   task automatic step(input bit e, input bit r);
      en  = e;
      rdy = r;
      @(negedge clk);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_b = 1'b0;
      en    = 1'b0;
      rdy   = 1'b0;
      @(negedge clk);
      rst_b = 1'b1;
   endtask

   // Polynomial x^16+x^14+x^13+x^11: tap t feeds from bit (16-t) of the right-shifting state.
   function automatic int unsigned lfsr_next(input int unsigned s);
      int taps[4] = '{16, 14, 13, 11};
      int unsigned fb = 0;
      foreach (taps[i]) fb ^= (s >> (16 - taps[i])) & 1;
      return ((s >> 1) | (fb << 15)) & 32'hFFFF;
   endfunction

   function automatic model_t model_init(input int unsigned seed);
      model_t m;
      m.val = 0; m.last = 0; m.data = 0; m.bursts = 0;
      m.remaining = 0; m.gap = 0; m.lfsr = seed;
      return m;
   endfunction

   // One rising edge of the behavioural model: remaining counts beats still owed in
   // the burst, gap counts idle cycles still owed after it.
   task automatic model_step(inout model_t m, input int mode, input bit e, input bit r);
      int unsigned s;
      bit          may_start;
      int          g;
      s = m.lfsr;
      may_start = 0;
      if (m.val) begin
         if (r) begin
            if (mode == 0) m.data = (m.data + 1) % 256;
            if (m.remaining == 1) begin
               m.bursts = (m.bursts + 1) % 65536;
               g = R_GAP_MIN + int'((s >> 8) & 255) % (R_GAP_MAX - R_GAP_MIN + 1);
               m.val = 0;
               if (g == 0) may_start = 1;
               else        m.gap = g;
            end else begin
               m.remaining--;
               if (mode == 1) m.data = int'(s & 255);
            end
         end
      end else if (m.gap > 0) begin
         m.gap--;
         if (m.gap == 0) may_start = 1;
      end else begin
         may_start = 1;
      end
      if (may_start && e) begin
         m.val = 1;
         m.remaining = R_LEN_MIN + int'(s & 255) % (R_LEN_MAX - R_LEN_MIN + 1);
         if (mode == 1) m.data = int'(s & 255);
      end
      m.last = m.val && (m.remaining == 1);
      m.lfsr = lfsr_next(s);
   endtask

   initial begin
      vec_t   tbl[9];
      model_t mr, mm;
      bit     e, r;

      rst_b = 1'b0;
      en    = 1'b0;
      rdy   = 1'b0;

      tbl[0] = '{1, 1, 1, 0, 0, 0};
      tbl[1] = '{1, 1, 1, 1, 0, 0};
      tbl[2] = '{1, 1, 1, 2, 1, 0};
      tbl[3] = '{1, 1, 0, 3, 0, 1};
      tbl[4] = '{1, 1, 0, 3, 0, 1};
      tbl[5] = '{1, 1, 1, 3, 0, 1};
      tbl[6] = '{1, 1, 1, 4, 0, 1};
      tbl[7] = '{1, 1, 1, 5, 1, 1};
      tbl[8] = '{1, 1, 0, 6, 0, 2};

      // Reset held from t=0, released at 25 ns on a falling edge; idle until en.
      #25 rst_b = 1'b1;
      for (int k = 0; k < 3; k++) begin
         step(1'b0, 1'b1);
         check("reset_val",    a_val,    0);
         check("reset_data",   a_data,   0);
         check("reset_last",   a_last,   0);
         check("reset_bursts", a_bursts, 0);
      end

      // Fixed 3-beat bursts with 2-cycle gaps.
      do_reset();
      for (int i = 0; i < 9; i++) begin
         step(tbl[i].en, tbl[i].rdy);
         check($sformatf("tbl%0d_val", i),    a_val,    tbl[i].val);
         check($sformatf("tbl%0d_data", i),   a_data,   tbl[i].data);
         check($sformatf("tbl%0d_last", i),   a_last,   tbl[i].last);
         check($sformatf("tbl%0d_bursts", i), a_bursts, tbl[i].bursts);
      end

      // Backpressure while beat 2 is presented.
      do_reset();
      step(1'b1, 1'b1);
      step(1'b1, 1'b1);
      check("bp_pre_data", a_data, 1);
      for (int k = 0; k < 4; k++) begin
         step(1'b1, 1'b0);
         check("bp_hold_val",  a_val,  1);
         check("bp_hold_data", a_data, 1);
         check("bp_hold_last", a_last, 0);
      end
      step(1'b1, 1'b1);
      check("bp_release_data", a_data, 2);
      check("bp_release_last", a_last, 1);
      step(1'b1, 1'b1);
      check("bp_done_val",    a_val,    0);
      check("bp_done_bursts", a_bursts, 1);

      // en dropped during beat 1: burst completes, then gap, then idle.
      do_reset();
      step(1'b1, 1'b1);
      check("endrop_b1_val", a_val, 1);
      step(1'b0, 1'b1);
      check("endrop_b2_data", a_data, 1);
      check("endrop_b2_val",  a_val,  1);
      step(1'b0, 1'b1);
      check("endrop_b3_data", a_data, 2);
      check("endrop_b3_last", a_last, 1);
      for (int k = 0; k < 5; k++) begin
         step(1'b0, 1'b1);
         check("endrop_idle_val",  a_val,  0);
         check("endrop_idle_last", a_last, 0);
      end
      check("endrop_bursts", a_bursts, 1);

      // Zero gap: back-to-back 2-beat bursts with no bubble.
      do_reset();
      for (int k = 1; k <= 8; k++) begin
         step(1'b1, 1'b1);
         check("gap0_val",    b_val,    1);
         check("gap0_data",   b_data,   k - 1);
         check("gap0_last",   b_last,   (k % 2) == 0);
         check("gap0_bursts", b_bursts, (k - 1) / 2);
      end
      step(1'b0, 1'b1);
      check("gap0_bursts_final", b_bursts, 4);

      // 4-bit data wrap, then asynchronous reset pulse mid-burst.
      do_reset();
      for (int k = 1; k <= 20; k++) begin
         step(1'b1, 1'b1);
         check("wrap_val",  c_val,  1);
         check("wrap_data", c_data, (k - 1) % 16);
      end
      check("wrap_bursts", c_bursts, 6);
      #2 rst_b = 1'b0;
      #1;
      check("async_val",    c_val,    0);
      check("async_data",   c_data,   0);
      check("async_last",   c_last,   0);
      check("async_bursts", c_bursts, 0);
      #1 rst_b = 1'b1;
      @(negedge clk);
      check("restart_val",  c_val,  1);
      check("restart_data", c_data, 0);
      check("restart_last", c_last, 0);
      step(1'b1, 1'b1);
      step(1'b1, 1'b1);
      check("restart_b3_data", c_data, 2);
      check("restart_b3_last", c_last, 1);

      // Randomized en/rdy against the model, counter and LFSR payload (seed 0 -> default).
      do_reset();
      mr = model_init(32'hACE1);
      mm = model_init(32'hACE1);
      for (int cyc = 0; cyc < 2000; cyc++) begin
         e = ($urandom_range(0, 9) != 0);
         r = ($urandom_range(0, 3) != 0);
         model_step(mr, 0, e, r);
         model_step(mm, 1, e, r);
         step(e, r);
         check("rnd_cnt_val",    r_val,    mr.val);
         check("rnd_cnt_data",   r_data,   mr.data);
         check("rnd_cnt_last",   r_last,   mr.last);
         check("rnd_cnt_bursts", r_bursts, mr.bursts);
         check("rnd_lfsr_val",    m_val,    mm.val);
         check("rnd_lfsr_data",   m_data,   mm.data);
         check("rnd_lfsr_last",   m_last,   mm.last);
         check("rnd_lfsr_bursts", m_bursts, mm.bursts);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
